inst_fetch_resp: RTL

Instruction-side memory responder: the slave end of the fetch handshake driven by the PC register and fetch stage. It accepts one word-aligned fetch request per handshake and returns the instruction word after a programmable number of wait states. The response is held under backpressure, and in-flight fetches can be dropped on a pipeline flush (jump or JTAG reset). A side write port lets the debug loader fill the instruction store.

---
 rtl/inst_fetch_resp.sv | 109 ++++++++++
 1 files changed

// File: rtl/inst_fetch_resp.sv
// Instruction-side fetch responder: single-outstanding request/response handshake with
// programmable wait states, flush, and a side loader port into the instruction store.
module inst_fetch_resp #(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned Depth      = 4096,
   parameter int unsigned WaitStates = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic [AddrWidth-1:0] addr_i,
   output logic                 ready_o,
   input  logic                 flush_i,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 rerr_o,
   input  logic                 rready_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] waddr_i,
   input  logic [DataWidth-1:0] wdata_i
);

   localparam int unsigned IdxW = $clog2(Depth);
   localparam logic [DataWidth-1:0] Nop = DataWidth'(32'h0000_0013);
   localparam logic [3:0] WaitInit = (WaitStates == 0) ? 4'd0 : 4'(WaitStates - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [DataWidth-1:0] rdata_q;
   logic                 rerr_q;
   logic [DataWidth-1:0] mem [Depth];

   logic                 accept;
   logic                 fault;
   logic                 load_ok;
   logic [IdxW-1:0]      fetch_idx;
   logic [IdxW-1:0]      load_idx;
   logic [AddrWidth-1:0] fetch_hi;
   logic [AddrWidth-1:0] load_hi;
   logic                 unused_waddr_lsb;

   assign fetch_idx        = addr_i[IdxW+1:2];
   assign fetch_hi         = addr_i >> (IdxW + 2);
   assign fault            = (addr_i[1:0] != 2'b00) | (fetch_hi != '0);
   assign load_idx         = waddr_i[IdxW+1:2];
   assign load_hi          = waddr_i >> (IdxW + 2);
   assign load_ok          = we_i & (load_hi == '0);
   assign unused_waddr_lsb = ^waddr_i[1:0];

   assign ready_o  = !flush_i & ((state_q == StIdle) | ((state_q == StResp) & rready_i));
   assign accept   = req_i & ready_o;
   assign rvalid_o = (state_q == StResp);
   assign rdata_o  = rdata_q;
   assign rerr_o   = rerr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         state_d = StIdle;
      end else if (accept) begin
         // Acceptance from IDLE or a completing RESP restarts the same way.
         if (WaitStates == 0) begin
            state_d = StResp;
         end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
         end
      end else begin
         case (state_q)
            StWait: begin
               if (cnt_q == 4'd0) state_d = StResp;
               else               cnt_d   = cnt_q - 4'd1;
            end
            StResp: begin
               if (rready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rdata_q <= fault ? Nop : mem[fetch_idx];
            rerr_q  <= fault;
         end
      end
   end

   // Store is not reset; a same-edge fetch of the written word sees the old contents.
   always_ff @(posedge clk_i) begin
      if (load_ok) mem[load_idx] <= wdata_i;
   end

endmodule
